// File: rtl/chan_regfile_pkg.sv
// Shared address map, bank offsets and commit FSM states for the NeoPixel
// channel configuration register file.
package regfile_pkg;

  localparam int ADDR_CTRL     = 'h00;
  localparam int ADDR_CHAN_CNT = 'h01;
  localparam int ADDR_STATUS   = 'h02;
  localparam int BANK_BASE     = 'h08;
  localparam int BANK_STRIDE   = 8;

  typedef enum logic [2:0] {
    OFS_T0H = 3'd0,
    OFS_T0L = 3'd1,
    OFS_T1H = 3'd2,
    OFS_T1L = 3'd3,
    OFS_LEN = 3'd4
  } bank_ofs_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } commit_state_e;

endpackage

// File: rtl/chan_regfile_bank.sv
// One channel bank: shadow timing/length registers, their active copies and
// the high+low period sums presented to the timing generator.
module chan_bank
  import regfile_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [2:0]        wr_ofs_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              load_i,
  input  logic [2:0]        rd_ofs_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [DATA_W-1:0] t0h_o,
  output logic [DATA_W:0]   t0s_o,
  output logic [DATA_W-1:0] t1h_o,
  output logic [DATA_W:0]   t1s_o,
  output logic [DATA_W-1:0] len_o
);

  logic [DATA_W-1:0] sh_t0h, sh_t0l, sh_t1h, sh_t1l, sh_len;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_t0h <= '0;
      sh_t0l <= '0;
      sh_t1h <= '0;
      sh_t1l <= '0;
      sh_len <= '0;
    end else if (wr_en_i) begin
      case (wr_ofs_i)
        OFS_T0H: sh_t0h <= wr_data_i;
        OFS_T0L: sh_t0l <= wr_data_i;
        OFS_T1H: sh_t1h <= wr_data_i;
        OFS_T1L: sh_t1l <= wr_data_i;
        OFS_LEN: sh_len <= wr_data_i;
        default: ;
      endcase
    end
  end

  // Sums are taken from the shadow registers as they stood before this edge,
  // so a write landing on the load edge waits for the next commit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      t0h_o <= '0;
      t0s_o <= '0;
      t1h_o <= '0;
      t1s_o <= '0;
      len_o <= '0;
    end else if (load_i) begin
      t0h_o <= sh_t0h;
      t0s_o <= {1'b0, sh_t0h} + {1'b0, sh_t0l};
      t1h_o <= sh_t1h;
      t1s_o <= {1'b0, sh_t1h} + {1'b0, sh_t1l};
      len_o <= sh_len;
    end
  end

  always_comb begin
    rd_data_o = '0;
    case (rd_ofs_i)
      OFS_T0H: rd_data_o = sh_t0h;
      OFS_T0L: rd_data_o = sh_t0l;
      OFS_T1H: rd_data_o = sh_t1h;
      OFS_T1L: rd_data_o = sh_t1l;
      OFS_LEN: rd_data_o = sh_len;
      default: rd_data_o = '0;
    endcase
  end

endmodule

// File: rtl/chan_regfile.sv
// Double-buffered channel configuration register file with frame-gated commit.
// Optional write range checking is enabled by REGFILE_RANGE_CHECK_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | active copy in use, no commit requested
// ST_PEND | commit requested, waiting for frame_idle_i to transfer
module chan_regfile
  import regfile_pkg::*;
#(
  parameter int CHAN_NUM = 8,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [ADDR_W-1:0]                reg_rd_addr_i,
  output logic [DATA_W-1:0]                reg_rd_data_o,
  input  logic                             reg_wr_en_i,
  input  logic [ADDR_W-1:0]                reg_wr_addr_i,
  input  logic [DATA_W-1:0]                reg_wr_data_i,
  input  logic                             frame_idle_i,
  output logic                             commit_pend_o,
  output logic                             commit_done_o,
  output logic [CHAN_NUM*DATA_W-1:0]       reg_t0h_time_o,
  output logic [CHAN_NUM*(DATA_W+1)-1:0]   reg_t0s_time_o,
  output logic [CHAN_NUM*DATA_W-1:0]       reg_t1h_time_o,
  output logic [CHAN_NUM*(DATA_W+1)-1:0]   reg_t1s_time_o,
  output logic [CHAN_NUM*DATA_W-1:0]       reg_chan_len_o,
  output logic [$clog2(CHAN_NUM+1)-1:0]    reg_chan_cnt_o
);

  localparam int CNT_W = $clog2(CHAN_NUM+1);
  localparam int BLK_W = ADDR_W - 3;

  // Address block 0 holds globals; block c+1 is channel c's bank.
  logic [BLK_W-1:0] wr_blk, rd_blk;
  logic [2:0]       wr_ofs, rd_ofs;
  logic             wr_bank_hit, rd_bank_hit;

  assign wr_blk = reg_wr_addr_i[ADDR_W-1:3];
  assign wr_ofs = reg_wr_addr_i[2:0];
  assign rd_blk = reg_rd_addr_i[ADDR_W-1:3];
  assign rd_ofs = reg_rd_addr_i[2:0];

  assign wr_bank_hit = (wr_blk != '0) && (32'(wr_blk) <= CHAN_NUM) && (wr_ofs <= 3'(OFS_LEN));
  assign rd_bank_hit = (rd_blk != '0) && (32'(rd_blk) <= CHAN_NUM) && (rd_ofs <= 3'(OFS_LEN));

  logic wr_ctrl, wr_cnt, wr_status, wr_bad, wr_ok;

  assign wr_ctrl   = reg_wr_en_i && (reg_wr_addr_i == ADDR_W'(ADDR_CTRL));
  assign wr_cnt    = reg_wr_en_i && (reg_wr_addr_i == ADDR_W'(ADDR_CHAN_CNT));
  assign wr_status = reg_wr_en_i && (reg_wr_addr_i == ADDR_W'(ADDR_STATUS));

  always_comb begin
    wr_bad = 1'b0;
`ifdef REGFILE_RANGE_CHECK_EN
    if (reg_wr_en_i && wr_bank_hit && (reg_wr_data_i == '0))
      wr_bad = 1'b1;
    if (wr_cnt && (32'(reg_wr_data_i) > CHAN_NUM))
      wr_bad = 1'b1;
`endif
  end

  assign wr_ok = reg_wr_en_i && !wr_bad;

  commit_state_e state_q, state_d;
  logic          load;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      commit_done_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      commit_done_o <= load;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: if (wr_ctrl && reg_wr_data_i[0]) state_d = ST_PEND;
      ST_PEND: begin
        if (frame_idle_i) begin
          load    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign commit_pend_o = (state_q == ST_PEND);

  logic [CNT_W-1:0] cnt_sh;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_sh         <= '0;
      reg_chan_cnt_o <= '0;
    end else begin
      if (wr_ok && wr_cnt) cnt_sh <= reg_wr_data_i[CNT_W-1:0];
      if (load)            reg_chan_cnt_o <= cnt_sh;
    end
  end

`ifdef REGFILE_RANGE_CHECK_EN
  logic err_q;

  // A fresh error outranks a clear request in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      err_q <= 1'b0;
    else if (wr_bad)
      err_q <= 1'b1;
    else if (wr_status && reg_wr_data_i[1])
      err_q <= 1'b0;
  end
`endif

  logic [DATA_W-1:0] bank_rd [CHAN_NUM];

  for (genvar c = 0; c < CHAN_NUM; c++) begin : g_bank
    chan_bank #(.DATA_W(DATA_W)) u_bank (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_en_i   (wr_ok && wr_bank_hit && (wr_blk == BLK_W'(c+1))),
      .wr_ofs_i  (wr_ofs),
      .wr_data_i (reg_wr_data_i),
      .load_i    (load),
      .rd_ofs_i  (rd_ofs),
      .rd_data_o (bank_rd[c]),
      .t0h_o     (reg_t0h_time_o[c*DATA_W +: DATA_W]),
      .t0s_o     (reg_t0s_time_o[c*(DATA_W+1) +: DATA_W+1]),
      .t1h_o     (reg_t1h_time_o[c*DATA_W +: DATA_W]),
      .t1s_o     (reg_t1s_time_o[c*(DATA_W+1) +: DATA_W+1]),
      .len_o     (reg_chan_len_o[c*DATA_W +: DATA_W])
    );
  end

  logic [DATA_W-1:0] rd_next;

  always_comb begin
    rd_next = '0;
    if (reg_rd_addr_i == ADDR_W'(ADDR_CHAN_CNT)) begin
      rd_next = DATA_W'(cnt_sh);
    end else if (reg_rd_addr_i == ADDR_W'(ADDR_STATUS)) begin
      rd_next[0] = commit_pend_o;
`ifdef REGFILE_RANGE_CHECK_EN
      rd_next[1] = err_q;
`endif
    end else if (rd_bank_hit) begin
      for (int c = 0; c < CHAN_NUM; c++)
        if (rd_blk == BLK_W'(c+1)) rd_next = bank_rd[c];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) reg_rd_data_o <= '0;
    else       reg_rd_data_o <= rd_next;
  end

endmodule

// File: tb/tb_chan_regfile.sv
// Directed plus randomized bench for chan_regfile against an array-based
// reference of the shadow/active copies and commit handshake.
module tb_chan_regfile;

  localparam int CHAN_NUM = 8;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 7;
  localparam int CNT_W    = $clog2(CHAN_NUM+1);

  logic                           clk_i = 1'b0;
  logic                           rst_i = 1'b1;
  logic [ADDR_W-1:0]              reg_rd_addr_i = '0;
  logic [DATA_W-1:0]              reg_rd_data_o;
  logic                           reg_wr_en_i = 1'b0;
  logic [ADDR_W-1:0]              reg_wr_addr_i = '0;
  logic [DATA_W-1:0]              reg_wr_data_i = '0;
  logic                           frame_idle_i = 1'b0;
  logic                           commit_pend_o;
  logic                           commit_done_o;
  logic [CHAN_NUM*DATA_W-1:0]     reg_t0h_time_o;
  logic [CHAN_NUM*(DATA_W+1)-1:0] reg_t0s_time_o;
  logic [CHAN_NUM*DATA_W-1:0]     reg_t1h_time_o;
  logic [CHAN_NUM*(DATA_W+1)-1:0] reg_t1s_time_o;
  logic [CHAN_NUM*DATA_W-1:0]     reg_chan_len_o;
  logic [CNT_W-1:0]               reg_chan_cnt_o;

  always #5 clk_i = ~clk_i;

  chan_regfile #(.CHAN_NUM(CHAN_NUM), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .reg_rd_addr_i  (reg_rd_addr_i),
    .reg_rd_data_o  (reg_rd_data_o),
    .reg_wr_en_i    (reg_wr_en_i),
    .reg_wr_addr_i  (reg_wr_addr_i),
    .reg_wr_data_i  (reg_wr_data_i),
    .frame_idle_i   (frame_idle_i),
    .commit_pend_o  (commit_pend_o),
    .commit_done_o  (commit_done_o),
    .reg_t0h_time_o (reg_t0h_time_o),
    .reg_t0s_time_o (reg_t0s_time_o),
    .reg_t1h_time_o (reg_t1h_time_o),
    .reg_t1s_time_o (reg_t1s_time_o),
    .reg_chan_len_o (reg_chan_len_o),
    .reg_chan_cnt_o (reg_chan_cnt_o)
  );

  // Reference: field index 0..4 = T0H, T0L, T1H, T1L, LEN.
  int sh [CHAN_NUM][5];
  int ac [CHAN_NUM][5];
  int sh_cnt, ac_cnt;
  bit m_pend, m_done;
`ifdef REGFILE_RANGE_CHECK_EN
  bit m_err;
`endif
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [CHAN_NUM*DATA_W-1:0] pack_f(input int f);
    logic [CHAN_NUM*DATA_W-1:0] v;
    v = '0;
    for (int c = 0; c < CHAN_NUM; c++) v[c*DATA_W +: DATA_W] = DATA_W'(ac[c][f]);
    return v;
  endfunction

  function automatic logic [CHAN_NUM*(DATA_W+1)-1:0] pack_s(input int fh, input int fl);
    logic [CHAN_NUM*(DATA_W+1)-1:0] v;
    v = '0;
    for (int c = 0; c < CHAN_NUM; c++)
      v[c*(DATA_W+1) +: DATA_W+1] = (DATA_W+1)'(ac[c][fh] + ac[c][fl]);
    return v;
  endfunction

  function automatic int model_read(input int a);
    int v;
    v = 0;
    if (a == 1) v = sh_cnt;
    else if (a == 2) begin
      v = m_pend ? 1 : 0;
`ifdef REGFILE_RANGE_CHECK_EN
      if (m_err) v += 2;
`endif
    end else if (a >= 8 && (a - 8) / 8 < CHAN_NUM && (a - 8) % 8 < 5)
      v = sh[(a-8)/8][(a-8)%8];
    return v;
  endfunction

  task automatic model_write(input int a, input int d);
    bit reject;
    reject = 1'b0;
    if (a == 1) begin
`ifdef REGFILE_RANGE_CHECK_EN
      reject = (d > CHAN_NUM);
      if (reject) m_err = 1'b1;
`endif
      if (!reject) sh_cnt = d % (1 << CNT_W);
    end else if (a == 2) begin
`ifdef REGFILE_RANGE_CHECK_EN
      if ((d & 2) != 0) m_err = 1'b0;
`endif
    end else if (a >= 8 && (a - 8) / 8 < CHAN_NUM && (a - 8) % 8 < 5) begin
`ifdef REGFILE_RANGE_CHECK_EN
      reject = (d == 0);
      if (reject) m_err = 1'b1;
`endif
      if (!reject) sh[(a-8)/8][(a-8)%8] = d;
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CHAN_NUM; c++)
      for (int f = 0; f < 5; f++) begin
        sh[c][f] = 0;
        ac[c][f] = 0;
      end
    sh_cnt = 0;
    ac_cnt = 0;
    m_pend = 1'b0;
    m_done = 1'b0;
`ifdef REGFILE_RANGE_CHECK_EN
    m_err = 1'b0;
`endif
  endtask

  task automatic check_outputs();
    check("pend", 128'(commit_pend_o), 128'(m_pend));
    check("done", 128'(commit_done_o), 128'(m_done));
    check("t0h",  128'(reg_t0h_time_o), 128'(pack_f(0)));
    check("t0s",  128'(reg_t0s_time_o), 128'(pack_s(0, 1)));
    check("t1h",  128'(reg_t1h_time_o), 128'(pack_f(2)));
    check("t1s",  128'(reg_t1s_time_o), 128'(pack_s(2, 3)));
    check("len",  128'(reg_chan_len_o), 128'(pack_f(4)));
    check("cnt",  128'(reg_chan_cnt_o), 128'(ac_cnt));
  endtask

  // One clock: drive at negedge, update the reference at the edge, check 1 ns later.
  task automatic cycle(input bit we, input int waddr, input int wdata, input bit idle, input int raddr);
    int  exp_rd;
    bit  xfer;
    @(negedge clk_i);
    reg_wr_en_i   = we;
    reg_wr_addr_i = ADDR_W'(waddr);
    reg_wr_data_i = DATA_W'(wdata);
    frame_idle_i  = idle;
    reg_rd_addr_i = ADDR_W'(raddr);
    @(posedge clk_i);
    exp_rd = model_read(raddr);
    xfer   = m_pend && idle;
    if (xfer) begin
      ac     = sh;
      ac_cnt = sh_cnt;
    end
    if (we) model_write(waddr, wdata);
    if (xfer) m_pend = 1'b0;
    else if (we && waddr == 0 && (wdata & 1) != 0) m_pend = 1'b1;
    m_done = xfer;
    #1;
    check("rd_data", 128'(reg_rd_data_o), 128'(exp_rd));
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i        = 1'b1;
    reg_wr_en_i  = 1'b0;
    frame_idle_i = 1'b0;
    repeat (2) @(posedge clk_i);
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    check("rst_rd", 128'(reg_rd_data_o), 128'(0));
    check_outputs();
  endtask

  task automatic commit_now();
    cycle(1, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0);
  endtask

  initial begin
    model_reset();
    do_reset();

    for (int a = 0; a < (1 << ADDR_W); a++) cycle(0, 0, 0, 0, a);

    // Shadow writes must not reach the active copy.
    cycle(1, 8, 'h01, 0, 0);
    cycle(1, 9, 'h12, 0, 0);
    cycle(1, 10, 'h23, 0, 0);
    cycle(1, 11, 'h34, 0, 0);
    cycle(1, 12, 'h3F, 0, 0);
    cycle(1, 1, 7, 0, 0);
    for (int a = 8; a <= 13; a++) cycle(0, 0, 0, 0, a);
    cycle(0, 0, 0, 0, 1);
    check("iso_cnt_rd", 128'(reg_rd_data_o), 128'(7));

    // Commit held off while the engine is mid-frame.
    cycle(1, 0, 1, 0, 2);
    repeat (20) cycle(0, 0, 0, 0, 2);
    check("pend_status_rd", 128'(reg_rd_data_o), 128'(1));
    cycle(0, 0, 0, 1, 0);
    check("t0s0", 128'(reg_t0s_time_o[0 +: DATA_W+1]), 128'('h013));
    check("t1s0", 128'(reg_t1s_time_o[0 +: DATA_W+1]), 128'('h057));
    check("cnt7", 128'(reg_chan_cnt_o), 128'(7));
    check("done_pulse", 128'(commit_done_o), 128'(1));
    cycle(0, 0, 0, 1, 0);

    // Largest sum needs the extra bit.
    cycle(1, 8 + 8*7, 'hFF, 0, 0);
    cycle(1, 8 + 8*7 + 1, 'hFF, 0, 0);
    commit_now();
    check("t0s7_max", 128'(reg_t0s_time_o[7*(DATA_W+1) +: DATA_W+1]), 128'('h1FE));

    // Write coinciding with the transfer edge stays in shadow.
    cycle(1, 20, 'h22, 0, 0);
    commit_now();
    cycle(1, 0, 1, 0, 0);
    cycle(1, 20, 'h10, 1, 20);
    check("coll_act_old", 128'(reg_chan_len_o[DATA_W +: DATA_W]), 128'('h22));
    cycle(0, 0, 0, 0, 20);
    check("coll_shadow", 128'(reg_rd_data_o), 128'('h10));
    commit_now();
    check("coll_act_new", 128'(reg_chan_len_o[DATA_W +: DATA_W]), 128'('h10));

    // Range checks.
    cycle(1, 8, 0, 0, 0);
    cycle(1, 1, CHAN_NUM + 1, 0, 0);
    cycle(0, 0, 0, 0, 2);
`ifdef REGFILE_RANGE_CHECK_EN
    check("err_status", 128'(reg_rd_data_o), 128'('h02));
    cycle(0, 0, 0, 0, 8);
    check("t0h_kept", 128'(reg_rd_data_o), 128'('h01));
    cycle(1, 2, 'h02, 0, 2);
    cycle(0, 0, 0, 0, 2);
    check("err_clear", 128'(reg_rd_data_o), 128'('h00));
`else
    check("no_err_status", 128'(reg_rd_data_o), 128'('h00));
    cycle(0, 0, 0, 0, 8);
    check("t0h_zero_taken", 128'(reg_rd_data_o), 128'('h00));
    cycle(0, 0, 0, 0, 1);
    check("cnt_big_taken", 128'(reg_rd_data_o), 128'(CHAN_NUM + 1));
`endif

    // Reset while pending discards the request.
    cycle(1, 0, 1, 0, 0);
    do_reset();
    repeat (3) cycle(0, 0, 0, 1, 2);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      int  sel, addr, data;
      bit  we, idle;
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        we  = ($urandom_range(0, 3) != 0);
        sel = $urandom_range(0, 9);
        if (sel == 0)      addr = 0;
        else if (sel == 1) addr = 1;
        else if (sel == 2) addr = 2;
        else if (sel == 3) addr = $urandom_range(0, (1 << ADDR_W) - 1);
        else               addr = $urandom_range(8, 8 + 8*CHAN_NUM - 1);
        if (addr == 1) data = $urandom_range(0, 2*CHAN_NUM);
        else           data = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
        idle = ($urandom_range(0, 2) == 0);
        cycle(we, addr, data, idle, $urandom_range(0, (1 << ADDR_W) - 1));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/chan_regfile.md
# chan_regfile

Parametrised, double-buffered configuration register file for the multi-channel NeoPixel output engine. It holds per-channel bit timing (T0H/T0L/T1H/T1L) and strip length for up to CHAN_NUM channels, plus a global channel count. Host writes land in a shadow copy. A commit request transfers all shadow values atomically to the active copy, but only when the output engine signals a frame boundary. The block sits between the host bus interface (SPI/register bridge) and the channel timing generators.

## Interface
- CHAN_NUM, 8: number of channel banks, 1..16.
- DATA_W, 8: register data width. Timing and length fields are DATA_W bits wide.
- ADDR_W, 7: register address width. Must satisfy 8 + 8·CHAN_NUM ≤ 2^ADDR_W.
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- reg_rd_addr_i  in  ADDR_W  read address
- reg_rd_data_o  out  DATA_W  read data, registered
- reg_wr_en_i  in  1  write strobe, one write per cycle
- reg_wr_addr_i  in  ADDR_W  write address
- reg_wr_data_i  in  DATA_W  write data
- frame_idle_i  in  1  output engine is between frames; commits are allowed
- commit_pend_o  out  1  a commit is requested but not yet applied
- commit_done_o  out  1  one-cycle pulse when the active copy is updated
- reg_t0h_time_o  out  CHAN_NUM×DATA_W  active T0H, one field per channel
- reg_t0s_time_o  out  CHAN_NUM×(DATA_W+1)  active T0H+T0L, one field per channel
- reg_t1h_time_o  out  CHAN_NUM×DATA_W  active T1H, one field per channel
- reg_t1s_time_o  out  CHAN_NUM×(DATA_W+1)  active T1H+T1L, one field per channel
- reg_chan_len_o  out  CHAN_NUM×DATA_W  active strip length, one field per channel
- reg_chan_cnt_o  out  $clog2(CHAN_NUM+1)  active enabled-channel count

## Operation
- Global address map:
  - 0x00 CTRL: write bit0=1 requests a commit; reads 0.
  - 0x01 CHAN_CNT: shadow channel count.
  - 0x02 STATUS: bit0 = pend (read-only); bit1 = err (write 1 to clear).
- Channel c bank: base 8+8c. Offsets: 0 T0H, 1 T0L, 2 T1H, 3 T1L, 4 LEN. Offsets 5..7 are reserved.
- Unmapped addresses (reserved offsets, c ≥ CHAN_NUM, 0x03..0x07):
  - reads return 0;
  - writes are ignored.
- Reads of a timing, length or count address return the shadow value.
- Commit state machine has two states, IDLE and PEND.
  - IDLE→PEND on a CTRL write with bit0=1.
  - PEND→IDLE on the first cycle with frame_idle_i=1. In that cycle, every active field loads from shadow.
  - The active T0S/T1S fields load the zero-extended sum H+L, so the (DATA_W+1)-bit sum cannot overflow.
  - commit_done_o pulses in the cycle after the transfer edge.
- A CTRL commit write while already in PEND is a no-op.
- Simultaneous shadow write and transfer in the same cycle: the active copy takes the pre-write shadow value. The new value stays in shadow for the next commit.
- Reset mid-PEND: the pending request is discarded.

## Timing
- Read latency 1 cycle: reg_rd_data_o is valid the cycle after the address is presented.
- A shadow write is visible on readback one cycle after the write edge.
- A CTRL write at edge N sets commit_pend_o after N. The earliest transfer is edge N+1, if frame_idle_i=1 before that edge. The active outputs change after N+1.
- Active outputs change only at transfer edges.
- Reset values of all outputs, shadow and active fields, and err: 0.

## Configuration
- REGFILE_RANGE_CHECK_EN defined:
  - A write is dropped and err is set (sticky) if it writes 0 to T0H/T0L/T1H/T1L/LEN, or a CHAN_CNT value > CHAN_NUM.
  - If a write of 1 to STATUS bit1 coincides with a new error, the error wins.
- REGFILE_RANGE_CHECK_EN undefined:
  - All writes are accepted unchecked.
  - STATUS bit1 reads 0.

## Structure
- Package regfile_pkg holds:
  - address constants: CTRL, CHAN_CNT, STATUS, BANK_BASE, bank stride 8;
  - bank offset enum: T0H, T0L, T1H, T1L, LEN;
  - the commit FSM state enum.
- Sub-module chan_bank holds one channel's shadow registers, active registers and sum logic. It takes a decoded write enable and a load strobe. The top level instantiates CHAN_NUM copies via generate.
- The top level holds address decode, the read mux, CHAN_CNT, STATUS and the FSM.

## Test plan
- Reset:
  - stimulus: release rst_i after 2 cycles, then read every mapped address;
  - required: all reads 0, all outputs 0, commit_pend_o=0.
- Shadow isolation:
  - stimulus: write ch0 T0H=0x01, T0L=0x12, T1H=0x23, T1L=0x34, LEN=0x3F; CHAN_CNT=7;
  - required: readback matches, and the active outputs stay 0.
- Commit gated by idle:
  - stimulus: hold frame_idle_i=0, write CTRL=1;
  - required: pend=1 and no output change for 20 cycles.
  - stimulus: raise frame_idle_i;
  - required: next edge gives reg_t0s_time_o[0]=0x013, reg_t1s_time_o[0]=0x057, reg_chan_cnt_o=7; one commit_done_o pulse.
- Sum width:
  - stimulus: ch7 T0H=0xFF, T0L=0xFF, commit;
  - required: reg_t0s_time_o[7]=0x1FE.
- Collision:
  - stimulus: write ch1 LEN=0x10 in the same cycle as the transfer;
  - required: active LEN=old value; shadow reads 0x10; next commit gives active LEN=0x10.
- Range check (macro defined):
  - stimulus: write T0H=0, then CHAN_CNT=CHAN_NUM+1;
  - required: both dropped, STATUS=0x02; writing STATUS=0x02 clears it.
  - stimulus: same writes, macro undefined;
  - required: values accepted.
